// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner, imem requester and small fetch FIFO towards decode
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_WORDS = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic        halted
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [31:0] LIMIT = 32'(4 * IMEM_WORDS);
  logic [31:0] pc;
  logic [31:0] pcs [FIFO_DEPTH];
  logic [31:0] ins [FIFO_DEPTH];
  logic        flt [FIFO_DEPTH];
  logic [CW-1:0] count;
  logic [AW-1:0] rd, wr;
  logic pop, push, fault;
  assign imem_addr = pc;
  assign out_valid = count != '0;
  assign out_pc    = pcs[rd];
  assign out_instr = ins[rd];
  assign out_fault = flt[rd];
  assign pop   = out_valid && out_ready;
  assign push  = !redirect_valid && !halted && (count < CW'(FIFO_DEPTH) || pop);
  assign fault = pc >= LIMIT;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd     <= '0;
      wr     <= '0;
      halted <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcs[i] <= '0;
        ins[i] <= '0;
        flt[i] <= 1'b0;
      end
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[31:2], 2'b00};
      count  <= '0;
      rd     <= '0;
      wr     <= '0;
      halted <= 1'b0;
    end else begin
      if (push) begin
        pcs[wr] <= pc;
        ins[wr] <= fault ? 32'h0000_0013 : imem_instr;
        flt[wr] <= fault;
        wr      <= wr + AW'(1);
        pc      <= fault ? pc : pc + 32'd4;
        halted  <= fault;
      end
      if (pop) rd <= rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
